ram_scrubber: RTL and testbench

RAM_SCRUBBER -- requirements
Module: ram_scrubber

---
 rtl/ram_scrubber.sv | 191 +++++++++++++++++++
 tb/tb_ram_scrubber.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_scrubber.sv
// ram_scrubber: walks a RAM, compares each word with an internal golden
// copy and rewrites any word that differs, keeping error statistics.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start                request one scrub pass (taken only when idle)
//   clr_err              clear err_count / err_flag / last_err_addr
//   golden_we/addr/data  golden-copy write port (taken only when idle)
//   ram_addr             RAM address
//   ram_rd_enable        RAM read strobe (data returns next cycle)
//   ram_wr_enable        RAM write strobe
//   ram_wr_data          RAM write data
//   ram_rd_data          RAM read data
//   busy                 high whenever a pass is in progress
//   done                 one-cycle pulse at the end of a pass
//   err_count            saturating count of corrected words
//   err_flag             sticky correction flag
//   last_err_addr        index of the most recently corrected word
module ram_scrubber #(
   parameter int NUM_ADDRS = 4,
   parameter int DATA_W    = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 clr_err,
   input  logic                 golden_we,
   input  logic [NUM_ADDRS-1:0] golden_addr,
   input  logic [DATA_W-1:0]    golden_data,
   output logic [NUM_ADDRS-1:0] ram_addr,
   output logic                 ram_rd_enable,
   output logic                 ram_wr_enable,
   output logic [DATA_W-1:0]    ram_wr_data,
   input  logic [DATA_W-1:0]    ram_rd_data,
   output logic                 busy,
   output logic                 done,
   output logic [7:0]           err_count,
   output logic                 err_flag,
   output logic [NUM_ADDRS-1:0] last_err_addr
);

   // Golden array only needs log2 index bits; the address ports are
   // NUM_ADDRS wide, so indices are truncated for the array select.
   localparam int AW = (NUM_ADDRS > 1) ? $clog2(NUM_ADDRS) : 1;
   localparam logic [NUM_ADDRS-1:0] LAST = NUM_ADDRS'(NUM_ADDRS - 1);
   localparam logic [NUM_ADDRS-1:0] ONE  = NUM_ADDRS'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_CMP,
      S_WR,
      S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [NUM_ADDRS-1:0] idx_q, idx_d;
   logic [DATA_W-1:0]    golden_q [NUM_ADDRS];
   logic [DATA_W-1:0]    gold_cur;

   logic [7:0]           cnt_q, cnt_d;
   logic                 flag_q, flag_d;
   logic [NUM_ADDRS-1:0] last_q, last_d;

   assign gold_cur = golden_q[idx_q[AW-1:0]];

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RD;
               idx_d   = '0;
            end
         end
         S_RD: state_d = S_CMP;
         S_CMP: begin
            if (ram_rd_data != gold_cur) begin
               state_d = S_WR;
            end else if (idx_q == LAST) begin
               state_d = S_DONE;
            end else begin
               state_d = S_RD;
               idx_d   = idx_q + ONE;
            end
         end
         S_WR: begin
            if (idx_q == LAST) begin
               state_d = S_DONE;
            end else begin
               state_d = S_RD;
               idx_d   = idx_q + ONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            idx_d   = '0;
         end
         default: begin
            state_d = S_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // Moore outputs
   always_comb begin
      ram_addr      = '0;
      ram_rd_enable = 1'b0;
      ram_wr_enable = 1'b0;
      ram_wr_data   = '0;
      done          = 1'b0;
      busy          = (state_q != S_IDLE);
      unique case (state_q)
         S_RD: begin
            ram_rd_enable = 1'b1;
            ram_addr      = idx_q;
         end
         S_WR: begin
            ram_wr_enable = 1'b1;
            ram_addr      = idx_q;
            ram_wr_data   = gold_cur;
         end
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   // Golden copy: writable only while idle; out-of-range indices dropped
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_ADDRS; i++) begin
            golden_q[i] <= {DATA_W{~i[0]}};
         end
      end else if (state_q == S_IDLE && golden_we
                   && golden_addr <= LAST) begin
         golden_q[golden_addr[AW-1:0]] <= golden_data;
      end
   end

   // Error statistics; a correction wins over a coincident clear,
   // so the clear only discards history before this word.
   always_comb begin
      cnt_d  = cnt_q;
      flag_d = flag_q;
      last_d = last_q;
      if (state_q == S_WR) begin
         if (clr_err) begin
            cnt_d = 8'd1;
         end else if (cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
         end
         flag_d = 1'b1;
         last_d = idx_q;
      end else if (clr_err) begin
         cnt_d  = '0;
         flag_d = 1'b0;
         last_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         flag_q <= 1'b0;
         last_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         flag_q <= flag_d;
         last_q <= last_d;
      end
   end

   assign err_count     = cnt_q;
   assign err_flag      = flag_q;
   assign last_err_addr = last_q;

endmodule

// File: tb/tb_ram_scrubber.sv
// tb_ram_scrubber: scoreboard bench; stimulus queues expected RAM writes
// and end-of-pass results, a negedge monitor pops and compares them.
module tb_ram_scrubber;

   typedef struct {
      logic [3:0] a;
      logic [9:0] d;
   } wr_t;

   typedef struct {
      int lat;
      int cnt;
      int flag;
      int addr;
      int rds;
      int wrs;
   } pass_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       clr_err = 1'b0;
   logic       golden_we = 1'b0;
   logic [3:0] golden_addr = '0;
   logic [9:0] golden_data = '0;
   logic [3:0] ram_addr;
   logic       ram_rd_enable;
   logic       ram_wr_enable;
   logic [9:0] ram_wr_data;
   logic [9:0] ram_rd_data;
   logic       busy;
   logic       done;
   logic [7:0] err_count;
   logic       err_flag;
   logic [3:0] last_err_addr;

   ram_scrubber #(.NUM_ADDRS(4), .DATA_W(10)) dut (
      .clk(clk), .rst(rst), .start(start), .clr_err(clr_err),
      .golden_we(golden_we), .golden_addr(golden_addr),
      .golden_data(golden_data), .ram_addr(ram_addr),
      .ram_rd_enable(ram_rd_enable), .ram_wr_enable(ram_wr_enable),
      .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data),
      .busy(busy), .done(done), .err_count(err_count),
      .err_flag(err_flag), .last_err_addr(last_err_addr)
   );

   always #5 clk = ~clk;

   // RAM model with a bench-side preload port
   logic [9:0] mem [16];
   logic       pre_we = 1'b0;
   logic [3:0] pre_a = '0;
   logic [9:0] pre_d = '0;

   always @(posedge clk) begin
      if (pre_we) mem[pre_a] <= pre_d;
      else if (ram_wr_enable) mem[ram_addr] <= ram_wr_data;
      if (ram_rd_enable) ram_rd_data <= mem[ram_addr];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   wr_t   wr_q[$];
   pass_t done_q[$];

   int checks = 0;
   int errors = 0;

   // Requests from stimulus to the monitor
   logic idle_chk = 1'b0;
   int   ie_cnt = 0, ie_flag = 0, ie_addr = 0;
   logic to_flag = 1'b0;
   logic fin_chk = 1'b0;

   function automatic void cmp(string n, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t",
                  n, act, exp, $time);
      end
   endfunction

   // Monitor / scoreboard
   bit in_pass = 0;
   int first_rd = 0;
   int p_rd = 0, p_wr = 0;

   always @(negedge clk) begin
      wr_t   w;
      pass_t e;
      if (rst) begin
         in_pass = 0;
      end else begin
         if (ram_rd_enable) begin
            if (!in_pass) begin
               in_pass = 1;
               first_rd = cyc;
               p_rd = 0;
               p_wr = 0;
            end
            p_rd++;
         end
         if (ram_wr_enable) begin
            p_wr++;
            if (wr_q.size() == 0) begin
               cmp("unexpected_wr", 1, 0);
            end else begin
               w = wr_q.pop_front();
               cmp("wr_addr", int'(ram_addr), int'(w.a));
               cmp("wr_data", int'(ram_wr_data), int'(w.d));
            end
         end
         if (done) begin
            in_pass = 0;
            if (done_q.size() == 0) begin
               cmp("unexpected_done", 1, 0);
            end else begin
               e = done_q.pop_front();
               cmp("latency", cyc - first_rd, e.lat);
               cmp("pass_err_count", int'(err_count), e.cnt);
               cmp("pass_err_flag", int'(err_flag), e.flag);
               cmp("pass_last_addr", int'(last_err_addr), e.addr);
               cmp("pass_reads", p_rd, e.rds);
               cmp("pass_writes", p_wr, e.wrs);
            end
         end
      end
      if (ram_rd_enable && ram_wr_enable) cmp("rd_wr_both", 1, 0);
      if (!ram_wr_enable && ram_wr_data != 0)
         cmp("wr_data_idle", int'(ram_wr_data), 0);
      if (!ram_rd_enable && !ram_wr_enable && ram_addr != 0)
         cmp("addr_idle", int'(ram_addr), 0);
      if (idle_chk) begin
         cmp("idle_busy", int'(busy), 0);
         cmp("idle_done", int'(done), 0);
         cmp("idle_rd", int'(ram_rd_enable), 0);
         cmp("idle_wr", int'(ram_wr_enable), 0);
         cmp("idle_err_count", int'(err_count), ie_cnt);
         cmp("idle_err_flag", int'(err_flag), ie_flag);
         cmp("idle_last_addr", int'(last_err_addr), ie_addr);
      end
      if (to_flag) cmp("done_timeout", 1, 0);
      if (fin_chk) begin
         cmp("wr_q_left", wr_q.size(), 0);
         cmp("done_q_left", done_q.size(), 0);
      end
   end

   // Stimulus
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_mem(input int a, input logic [9:0] d);
      pre_we = 1'b1;
      pre_a = 4'(a);
      pre_d = d;
      tick();
      pre_we = 1'b0;
   endtask

   task automatic load(input logic [9:0] d0, d1, d2, d3);
      set_mem(0, d0);
      set_mem(1, d1);
      set_mem(2, d2);
      set_mem(3, d3);
   endtask

   task automatic exp_wr(input int a, input logic [9:0] d);
      wr_t w;
      w.a = 4'(a);
      w.d = d;
      wr_q.push_back(w);
   endtask

   task automatic expect_idle(input int c, input int f, input int a);
      ie_cnt = c;
      ie_flag = f;
      ie_addr = a;
      idle_chk = 1'b1;
      tick();
      idle_chk = 1'b0;
   endtask

   task automatic clear_err();
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      expect_idle(0, 0, 0);
   endtask

   // mode 1: golden_we mid-pass, 2: clr_err in WR, 3: start mid-pass
   task automatic run_pass(input int lat, cnt, flag, addr, wrs,
                           input int mode);
      pass_t e;
      bit got;
      e.lat = lat;
      e.cnt = cnt;
      e.flag = flag;
      e.addr = addr;
      e.rds = 4;
      e.wrs = wrs;
      done_q.push_back(e);
      start = 1'b1;
      tick();
      start = 1'b0;
      got = 0;
      for (int i = 0; i < 100; i++) begin
         if (mode == 1 && i == 2) begin
            golden_we = 1'b1;
            golden_addr = 4'd2;
            golden_data = 10'h123;
         end
         if (mode == 2 && ram_wr_enable) clr_err = 1'b1;
         if (mode == 3 && i == 3) start = 1'b1;
         tick();
         golden_we = 1'b0;
         clr_err = 1'b0;
         start = 1'b0;
         if (done) begin
            got = 1;
            break;
         end
      end
      if (!got) begin
         to_flag = 1'b1;
         tick();
         to_flag = 1'b0;
      end
      tick();
   endtask

   initial begin
      tick();
      tick();
      rst = 1'b0;
      expect_idle(0, 0, 0);

      // clean pass
      load(10'h3FF, 10'h000, 10'h3FF, 10'h000);
      run_pass(8, 0, 0, 0, 0, 0);

      // single corrupted word
      set_mem(1, 10'h155);
      exp_wr(1, 10'h000);
      run_pass(9, 1, 1, 1, 1, 0);
      clear_err();

      // every word inverted, golden write attempted mid-pass
      load(10'h000, 10'h3FF, 10'h000, 10'h3FF);
      exp_wr(0, 10'h3FF);
      exp_wr(1, 10'h000);
      exp_wr(2, 10'h3FF);
      exp_wr(3, 10'h000);
      run_pass(12, 4, 1, 3, 4, 1);
      run_pass(8, 4, 1, 3, 0, 0);
      clear_err();

      // golden update while idle
      golden_we = 1'b1;
      golden_addr = 4'd2;
      golden_data = 10'h2AA;
      tick();
      golden_we = 1'b0;
      exp_wr(2, 10'h2AA);
      run_pass(9, 1, 1, 2, 1, 0);
      run_pass(8, 1, 1, 2, 0, 0);

      // reset while in CMP
      set_mem(0, 10'h000);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      expect_idle(0, 0, 0);
      tick();
      tick();
      set_mem(2, 10'h3FF);

      // word 0 untouched by the aborted pass; then clr_err in WR
      exp_wr(0, 10'h3FF);
      run_pass(9, 1, 1, 0, 1, 0);
      set_mem(3, 10'h3FF);
      exp_wr(3, 10'h000);
      run_pass(9, 1, 1, 3, 1, 2);
      clear_err();

      // saturation: 252 + 3 corrections, then one more
      for (int k = 1; k <= 63; k++) begin
         load(10'h000, 10'h3FF, 10'h000, 10'h3FF);
         exp_wr(0, 10'h3FF);
         exp_wr(1, 10'h000);
         exp_wr(2, 10'h3FF);
         exp_wr(3, 10'h000);
         run_pass(12, 4 * k, 1, 3, 4, 0);
      end
      load(10'h000, 10'h3FF, 10'h3FF, 10'h3FF);
      exp_wr(0, 10'h3FF);
      exp_wr(1, 10'h000);
      exp_wr(3, 10'h000);
      run_pass(11, 255, 1, 3, 3, 0);
      set_mem(2, 10'h000);
      exp_wr(2, 10'h3FF);
      run_pass(9, 255, 1, 2, 1, 3);
      for (int i = 0; i < 12; i++) tick();
      expect_idle(255, 1, 2);

      fin_chk = 1'b1;
      tick();
      fin_chk = 1'b0;
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
